// File: rtl/comp_serie_pkg.sv
// Shared types for the bit-serial comparator: FSM states and the compare-mode encoding.
package comp_serie_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} estado_t;

  localparam logic MODO_UNS = 1'b0;
  localparam logic MODO_SGN = 1'b1;
endpackage

// File: rtl/comp_serie_d_i_celda.sv
// One-bit comparator cell: folds bit pair (a,b) into the running LSB-first lt/eq state.
module celda_comp_d_i (
  input  logic a,
  input  logic b,
  input  logic lt,
  input  logic eq,
  input  logic msb_sgn,
  output logic lt_n,
  output logic eq_n
);
  logic same;

  assign same = ~(a ^ b);
  // On a signed sign bit the ordering inverts: a set sign bit means the smaller value.
  assign lt_n = msb_sgn ? ((a & ~b) | (same & lt)) : ((~a & b) | (same & lt));
  assign eq_n = eq & same;
endmodule

// File: rtl/comp_serie_d_i.sv
// Bit-serial LSB-first magnitude comparator over CH channel pairs, with valid/ready handshake.
module comp_serie_d_i
  import comp_serie_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                modo,
  input  logic [CH*WIDTH-1:0] a_in,
  input  logic [CH*WIDTH-1:0] b_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH-1:0]       menor,
  output logic [CH-1:0]       igual,
  output logic [CH-1:0]       mayor
);
  localparam int CW = $clog2(WIDTH);

  estado_t                    state_q, state_d;
  logic [CW-1:0]              cnt_q;
  logic                       modo_q;
  logic [CH-1:0][WIDTH-1:0]   sa_q, sb_q;
  logic [CH-1:0]              lt_q, eq_q, lt_n, eq_n;
  logic                       last, msb_sgn;

  assign last      = (cnt_q == CW'(WIDTH - 1));
  assign msb_sgn   = (modo_q == MODO_SGN) && last;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  for (genvar g = 0; g < CH; g++) begin : g_celda
    celda_comp_d_i u_celda (
      .a      (sa_q[g][0]),
      .b      (sb_q[g][0]),
      .lt     (lt_q[g]),
      .eq     (eq_q[g]),
      .msb_sgn(msb_sgn),
      .lt_n   (lt_n[g]),
      .eq_n   (eq_n[g])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      modo_q <= MODO_UNS;
      sa_q   <= '0;
      sb_q   <= '0;
      lt_q   <= '0;
      eq_q   <= '0;
      menor  <= '0;
      igual  <= '0;
      mayor  <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sa_q   <= a_in;
          sb_q   <= b_in;
          modo_q <= modo;
          cnt_q  <= '0;
          lt_q   <= '0;
          eq_q   <= '1;
        end
        RUN: begin
          for (int k = 0; k < CH; k++) begin
            sa_q[k] <= sa_q[k] >> 1;
            sb_q[k] <= sb_q[k] >> 1;
          end
          lt_q <= lt_n;
          eq_q <= eq_n;
          // Flags only move on the final bit; they hold through IDLE/RUN otherwise.
          if (last) begin
            menor <= lt_n;
            igual <= eq_n;
            mayor <= ~lt_n & ~eq_n;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_comp_serie_d_i.sv
// Directed bench for comp_serie_d_i: single-channel modes, 4-channel packing, backpressure, reset abort.
module tb_comp_serie_d_i;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, modo = 1'b0;
  logic        in_ready, out_valid;
  logic [7:0]  a_in = '0, b_in = '0;
  logic [0:0]  menor, igual, mayor;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b0, modo4 = 1'b0;
  logic        in_ready4, out_valid4;
  logic [31:0] a_in4 = '0, b_in4 = '0;
  logic [3:0]  menor4, igual4, mayor4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comp_serie_d_i #(.WIDTH(8), .CH(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .modo(modo),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .menor(menor), .igual(igual), .mayor(mayor)
  );

  comp_serie_d_i #(.WIDTH(8), .CH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .modo(modo4),
    .a_in(a_in4), .b_in(b_in4), .out_valid(out_valid4), .out_ready(out_ready4),
    .menor(menor4), .igual(igual4), .mayor(mayor4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one op, scramble the inputs, then measure latency and check {menor,igual,mayor}.
  task automatic start_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic m, input logic [2:0] exp_flags);
    int n;
    @(negedge clk);
    a_in = a; b_in = b; modo = m; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = ~a; b_in = ~b; modo = ~m;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd8);
    chk({tag, "_flags"}, 32'({menor, igual, mayor}), 32'(exp_flags));
  endtask

  task automatic retire(input string tag);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, "_ret_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_ret_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", 32'({menor, igual, mayor}), 32'd0);
    chk("rst_flags4", 32'({menor4, igual4, mayor4}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    start_op("u80_7f", 8'h80, 8'h7F, 1'b0, 3'b001); retire("u80_7f");
    start_op("s80_7f", 8'h80, 8'h7F, 1'b1, 3'b100); retire("s80_7f");
    start_op("ua5",    8'hA5, 8'hA5, 1'b0, 3'b010); retire("ua5");
    start_op("sa5",    8'hA5, 8'hA5, 1'b1, 3'b010); retire("sa5");
    start_op("u00_ff", 8'h00, 8'hFF, 1'b0, 3'b100); retire("u00_ff");
    start_op("s00_ff", 8'h00, 8'hFF, 1'b1, 3'b001);

    // Backpressure: hold result 5 cycles while in_valid toggles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_valid = i[0]; a_in = 8'h01; b_in = 8'h02; modo = 1'b0;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_flags", 32'({menor, igual, mayor}), 32'b001);
    end
    // Retire with in_valid high: must not be taken as a new op.
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b0;
    chk("bp_ret_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_no_accept", 32'(in_ready), 32'd1);
    chk("bp_flags_hold", 32'({menor, igual, mayor}), 32'b001);

    // Four channels: (3,5) (9,9) (200,17) (0,1).
    @(negedge clk);
    a_in4 = {8'd0, 8'd200, 8'd9, 8'd3};
    b_in4 = {8'd1, 8'd17,  8'd9, 8'd5};
    modo4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk); #1; in_valid4 = 1'b0; a_in4 = '0; b_in4 = '1;
    n = 0;
    while (!out_valid4 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("ch4_lat", 32'(n), 32'd8);
    chk("ch4_menor", 32'(menor4), 32'b1001);
    chk("ch4_igual", 32'(igual4), 32'b0010);
    chk("ch4_mayor", 32'(mayor4), 32'b0100);
    @(negedge clk); out_ready4 = 1'b1;
    @(posedge clk); #1; out_ready4 = 1'b0;
    chk("ch4_ret", 32'(in_ready4), 32'd1);

    // Reset during RUN cycle 3 aborts the op.
    @(negedge clk); a_in = 8'h00; b_in = 8'hFF; modo = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("abort_flags", 32'({menor, igual, mayor}), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      chk("abort_idle", 32'({in_ready, out_valid}), 32'b10);
    end
    start_op("post_abort", 8'h10, 8'h01, 1'b0, 3'b001); retire("post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
